// File: rtl/step_ctrl_pkg.sv
// Shared constants, repeat-FSM encoding and width helper for the button step controller.
package step_ctrl_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_HOLD   = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int clog2_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_step_ctrl_debounce.sv
// One push-button path: 2-FF synchroniser, counter debouncer and rising-edge detector.
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = clog2_width(DEBOUNCE_CYCLES);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic          lvl_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      // Any sample agreeing with the current level restarts the stability count.
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = lvl;
  assign rise  = lvl & ~lvl_d;

endmodule

// File: rtl/button_step_ctrl.sv
// Merges debounced up/down buttons into a registered step pulse and direction level.
// Optional auto-repeat while a single button is held: define AUTO_REPEAT_EN.
module button_step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic en,
  output logic updown
);

  logic rise_up;
  logic rise_down;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = clog2_width(RMAX + 1);

  logic          lvl_up;
  logic          lvl_down;
  logic          active_lvl;
  logic          rep_dir;
  logic [RW-1:0] rcnt;
  rep_state_t    rep_state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .reset(reset), .raw(btn_up), .level(lvl_up), .rise(rise_up)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .reset(reset), .raw(btn_down), .level(lvl_down), .rise(rise_down)
  );

  assign active_lvl = rep_dir ? lvl_up : lvl_down;

  always_ff @(posedge clk) begin
    if (reset) begin
      en        <= 1'b0;
      updown    <= DIR_UP;
      rep_state <= REP_IDLE;
      rcnt      <= '0;
      rep_dir   <= DIR_UP;
    end else begin
      en <= 1'b0;
      if (rise_up ^ rise_down) begin
        en     <= 1'b1;
        updown <= rise_up ? DIR_UP : DIR_DOWN;
      end
      case (rep_state)
        REP_IDLE: begin
          if (rise_up | rise_down) begin
            rep_state <= REP_HOLD;
            rcnt      <= '0;
            rep_dir   <= rise_up;
          end
        end
        REP_HOLD, REP_REPEAT: begin
          // Second button pressed or active button released: abandon repeat silently.
          if ((lvl_up & lvl_down) || !active_lvl) begin
            rep_state <= REP_IDLE;
            rcnt      <= '0;
          end else if (rep_state == REP_HOLD) begin
            if (rcnt == RW'(HOLD_CYCLES)) begin
              en        <= 1'b1;
              updown    <= rep_dir;
              rep_state <= REP_REPEAT;
              rcnt      <= '0;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end else begin
            if (rcnt == RW'(REPEAT_CYCLES - 1)) begin
              en     <= 1'b1;
              updown <= rep_dir;
              rcnt   <= '0;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
        end
        default: begin
          rep_state <= REP_IDLE;
          rcnt      <= '0;
        end
      endcase
    end
  end
`else
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .reset(reset), .raw(btn_up), .level(), .rise(rise_up)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .reset(reset), .raw(btn_down), .level(), .rise(rise_down)
  );

  // Simultaneous rises are a conflict: no step, direction held.
  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= 1'b0;
      updown <= DIR_UP;
    end else if (rise_up && !rise_down) begin
      en     <= 1'b1;
      updown <= DIR_UP;
    end else if (rise_down && !rise_up) begin
      en     <= 1'b1;
      updown <= DIR_DOWN;
    end else begin
      en <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_button_step_ctrl.sv
// Directed plus randomized bench for button_step_ctrl against a sample-history reference model.
module tb_button_step_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic en;
  logic updown;

  always #5 clk = ~clk;

  button_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .en(en),
    .updown(updown)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int edge_n = 0;
  int pulses = 0;
  int first_pulse = -1;

  // Reference model: raw samples since reset; a level changes once the synchronised
  // sample (two edges old) has disagreed with it for D evaluations since its last change.
  logic       hist_u[$];
  logic       hist_d[$];
  logic       m_lvl[2];
  int         m_last[2];
  logic       m_rise[2];
  logic       m_ud = 1'b1;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, want, edge_n);
    end
  endtask

  function automatic logic s2_of(input int b, input int idx);
    if (idx < 2) return 1'b0;
    return (b == 0) ? hist_u[idx-2] : hist_d[idx-2];
  endfunction

  function automatic void model_btn(input int b, input logic r, input logic rst);
    int   i;
    logic flip;
    m_rise[b] = 1'b0;
    if (rst) begin
      if (b == 0) hist_u.delete(); else hist_d.delete();
      m_lvl[b]  = 1'b0;
      m_last[b] = -1;
      return;
    end
    if (b == 0) begin i = hist_u.size(); hist_u.push_back(r); end
    else begin i = hist_d.size(); hist_d.push_back(r); end
    flip = (i - D + 1 > m_last[b]);
    for (int k = i - D + 1; k <= i && flip; k++)
      if (s2_of(b, k) == m_lvl[b]) flip = 1'b0;
    if (flip) begin
      m_lvl[b]  = ~m_lvl[b];
      m_last[b] = i;
      m_rise[b] = m_lvl[b];
    end
  endfunction

  function automatic void model_edge();
    logic ru, rd, e;
    ru = m_rise[0];
    rd = m_rise[1];
    e  = 1'b0;
    if (reset) m_ud = 1'b1;
    else if (ru && !rd) begin e = 1'b1; m_ud = 1'b1; end
    else if (rd && !ru) begin e = 1'b1; m_ud = 1'b0; end
    model_btn(0, btn_up, reset);
    model_btn(1, btn_down, reset);
    exp_q.push_back({e, m_ud});
  endfunction

  task automatic tick();
    logic [1:0] w;
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    w = exp_q.pop_front();
    chk("en", en, w[1]);
    chk("updown", updown, w[0]);
    if (en === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = edge_n;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    pulses = 0;
    first_pulse = -1;
  endtask

  int start_e;
  int bounce[5] = '{1, 0, 1, 1, 0};

  initial begin
    m_lvl  = '{1'b0, 1'b0};
    m_last = '{-1, -1};
    m_rise = '{1'b0, 1'b0};
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;

    // Reset and idle
    ticks(3);
    chk("reset_en", en, 1'b0);
    chk("reset_updown", updown, 1'b1);
    reset = 1'b0;
    clear_counts();
    ticks(20);
    chk("idle_pulses", pulses, 0);
    chk("idle_updown", updown, 1'b1);

    // Clean up press: one pulse at edge D+3 counting the first sampling edge
    clear_counts();
    btn_up = 1'b1;
    start_e = edge_n + 1;
    ticks(30);
    chk("up_pulses", pulses, 1);
    chk("up_latency", first_pulse - start_e + 1, D + 3);
    chk("up_dir", updown, 1'b1);
    btn_up = 1'b0;
    clear_counts();
    ticks(15);
    chk("up_release_pulses", pulses, 0);

    // Bouncing down press
    clear_counts();
    foreach (bounce[i]) begin
      btn_down = bounce[i][0];
      tick();
    end
    chk("bounce_no_pulse", pulses, 0);
    btn_down = 1'b1;
    start_e = edge_n + 1;
    ticks(20);
    chk("down_pulses", pulses, 1);
    chk("down_latency", first_pulse - start_e + 1, D + 3);
    chk("down_dir", updown, 1'b0);
    btn_down = 1'b0;
    ticks(15);

    // Simultaneous rise is a conflict; re-pressing up afterwards steps up
    clear_counts();
    btn_up = 1'b1; btn_down = 1'b1;
    ticks(20);
    chk("conflict_pulses", pulses, 0);
    chk("conflict_dir_held", updown, 1'b0);
    btn_up = 1'b0;
    ticks(10);
    btn_up = 1'b1;
    ticks(20);
    chk("repress_pulses", pulses, 1);
    chk("repress_dir", updown, 1'b1);
    btn_up = 1'b0; btn_down = 1'b0;
    ticks(15);

    // Reset in the middle of a held press
    clear_counts();
    btn_up = 1'b1;
    ticks(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_no_pulse", pulses, 0);
    start_e = edge_n + 1;
    ticks(20);
    chk("reset_mid_pulses", pulses, 1);
    chk("reset_mid_latency", first_pulse - start_e + 1, D + 3);
    btn_up = 1'b0;
    ticks(15);

    // Randomized segments of bouncing, holds, overlaps and occasional resets
    for (int s = 0; s < 150; s++) begin
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 29) == 0);
      if (reset) begin
        tick();
        reset = 1'b0;
      end
      ticks($urandom_range(1, 12));
    end
    btn_up = 1'b0; btn_down = 1'b0;
    ticks(15);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/button_step_ctrl.md
Name: button_step_ctrl

Overview:
- Upstream conditioner for the modulo-n up/down binary counter. Converts two raw, asynchronous, bouncing push-buttons (up, down) into the counter's step controls: a single-cycle `en` pulse plus a held `updown` direction level.
- Per button: 2-FF synchroniser, then counter-based debouncer, then rising-edge detector.
- An arbiter merges the two buttons into one registered step command.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a debounced level changes (5 ms at 100 MHz); minimum 2.
- HOLD_CYCLES, 50000000: held-button delay before auto-repeat starts; used only with AUTO_REPEAT_EN.
- REPEAT_CYCLES, 20000000: auto-repeat step period; used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- btn_up  input  1  raw up button, asynchronous, active-high.
- btn_down  input  1  raw down button, asynchronous, active-high.
- en  output  1  registered one-cycle step pulse; drives counter `en`.
- updown  output  1  registered direction: 1 = up, 0 = down; drives counter `updown`.

Behaviour:
- Reset (synchronous): sync FFs, debounce counters, debounced levels, edge registers, en and updown cleared. Reset values: en=0, updown=1.
- Synchroniser: s1 <= raw, s2 <= s1; s2 lags raw by 2 edges.
- Debouncer state: lvl (reset 0) and cnt (width clog2(DEBOUNCE_CYCLES)).
  - If s2==lvl: cnt <= 0.
  - Else if cnt==DEBOUNCE_CYCLES-1: lvl <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count; lvl does not change.
- Edge detector: lvl_d <= lvl; rise = lvl & ~lvl_d. Release edges generate nothing.
- Arbiter, evaluated each cycle:
  - rise_up only: en <= 1, updown <= 1.
  - rise_down only: en <= 1, updown <= 0.
  - Both rise in the same cycle: conflict, en <= 0, updown unchanged.
  - Neither: en <= 0, updown holds.
- Latency: raw stable high from before edge k → en=1 after edge k+DEBOUNCE_CYCLES+2, i.e. on the (DEBOUNCE_CYCLES+3)-th edge counting k as the first.
- updown changes only in the same edge that asserts en. It is therefore valid whenever en=1 and stable between pulses.
- en is never high on two consecutive cycles, except via auto-repeat with REPEAT_CYCLES=1 (disallowed).
- Reset mid-debounce: count lost, no pulse.
- Button held through reset release: lvl restarts at 0, so exactly one press pulse is issued DEBOUNCE_CYCLES+2 edges after the first non-reset edge. This is intended behaviour.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: a per-module repeat FSM (IDLE, HOLD, REPEAT) with an rcnt counter.
  - IDLE → HOLD on any rise; rcnt cleared.
  - HOLD: after HOLD_CYCLES cycles with exactly one lvl high, emit a step in that button's direction, then → REPEAT.
  - REPEAT: emit a step every REPEAT_CYCLES cycles.
  - Both lvl high, or the active lvl low → IDLE immediately; no step in that cycle.
  - Repeat steps obey the same en/updown registration as press steps.
- Undefined: FSM and rcnt are not synthesised; holding a button yields exactly one step. HOLD_CYCLES and REPEAT_CYCLES are ignored.

Decomposition:
- Package step_ctrl_pkg: direction constants DIR_UP=1, DIR_DOWN=0; repeat-FSM state encodings; clog2-based width helper.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk, reset, raw, level, rise): synchroniser, debouncer and edge detector. Instantiated twice.
- The top level holds the arbiter and the optional repeat FSM.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=4):
- Reset then idle 20 cycles → en=0 throughout, updown=1.
- btn_up held high from edge 0 for 30 cycles → single en pulse on edge 7, updown=1; no further pulses; release produces nothing.
- btn_down bounces (1,0,1,1,0 at 1-cycle intervals), then stays high → no pulse during bounce; exactly one pulse 7 edges after the final rise, updown=0.
- btn_up and btn_down rise on the same cycle and are held → no en pulse, updown unchanged; releasing btn_up then pressing it again → up pulse.
- reset asserted for 1 cycle at edge 4 of a btn_up press, button still held → no pulse before reset; one pulse 6 edges after reset deasserts.
- With AUTO_REPEAT_EN, btn_up held 40 cycles → press pulse at edge 7, repeat pulses at edges 16, 20, 24, …; a btn_down press mid-repeat stops the repeats.
